rggen_bit_field_ext: RTL and testbench
======================================

// Module: rggen_bit_field_ext
// PURPOSE
//  Parametrised bit-field storage element. Sits behind a register block's per-field access port.
//  Generalises plain RW storage:
//   - selectable software write actions and read side-effects
//   - write-once lock
//   - per-bit hardware write/set/clear
//   - registered write/read trigger pulses
//  One instance per field, WIDTH bits wide.
// PARAMETERS
//  WIDTH          32         field width in bits, 1..64
//  INITIAL_VALUE  '0         reset value of the field, WIDTH bits
//  SW_READABLE    1          1: o_sw_read_data = value; 0: o_sw_read_data = '0
//  SW_WRITE_ACTION RGGEN_WRITE_DEFAULT  one of DEFAULT, NONE, CLEAR_1, SET_1, TOGGLE_1, CLEAR_0, SET_0, CLEAR_ALL, SET_ALL
//  SW_READ_ACTION RGGEN_READ_NONE       one of NONE, CLEAR, SET
//  SW_WRITE_ONCE  0          1: only the first accepted software write takes effect until reset
//  HW_ACCESS      1          1: hardware ports active; 0: hardware ports ignored
// PORTS
//  i_clk            in   1      clock
//  i_rst_n          in   1      asynchronous active-low reset
//  i_sw_write_valid in   1      software write strobe, one cycle per access
//  i_sw_read_valid  in   1      software read strobe, one cycle per access
//  i_sw_mask        in   WIDTH  per-bit byte-lane/field mask for the access
//  i_sw_write_data  in   WIDTH  software write data
//  o_sw_read_data   out  WIDTH  read data returned to the register
//  o_sw_value       out  WIDTH  current field value (same as o_value)
//  i_hw_write_enable in  1      hardware load strobe
//  i_hw_write_data  in   WIDTH  hardware load data
//  i_hw_set         in   WIDTH  per-bit hardware set
//  i_hw_clear       in   WIDTH  per-bit hardware clear
//  o_value          out  WIDTH  field value to logic
//  o_write_trigger  out  WIDTH  per-bit pulse, 1 cycle after accepted software write
//  o_read_trigger   out  WIDTH  per-bit pulse, 1 cycle after software read
// BEHAVIOUR
//  Reset (async, i_rst_n=0):
//   - value <= INITIAL_VALUE
//   - triggers <= '0
//   - written flag <= 0
//   - reset mid-access discards the access
//  Read data and value are combinational from the value register.
//  A read returns the pre-side-effect value; side effects are visible on the next cycle.
//  Per bit b, the next value is computed in stages:
//   - sw_wr[b] = i_sw_write_valid & i_sw_mask[b] & ~(SW_WRITE_ONCE & written)
//   - sw_rd[b] = i_sw_read_valid & i_sw_mask[b]
//   - s1: sw_wr ? write_action(value, wdata) : sw_rd ? read_action(value) : value
//   - write_action by mode:
//       DEFAULT = wdata; NONE = value
//       CLEAR_1 = value & ~wdata; SET_1 = value | wdata; TOGGLE_1 = value ^ wdata
//       CLEAR_0 = value & wdata; SET_0 = value | ~wdata
//       CLEAR_ALL = 0; SET_ALL = 1
//   - read_action by mode: NONE = value; CLEAR = 0; SET = 1
//   - s2 = (HW_ACCESS & i_hw_write_enable & ~sw_wr[b]) ? i_hw_write_data[b] : s1
//   - next = (s2 & ~hw_clear[b]) | hw_set[b]; hw_set wins over hw_clear
//  Priority rationale: hardware set/clear override software so events are never lost.
//  A hardware load yields to a same-cycle software write on that bit.
//  Write and read on the same cycle: the write action wins; both triggers fire.
//  Write-once:
//   - written <= 1 on the first cycle where any sw_wr bit is set
//   - later software writes: no value change and no write trigger
//   - hardware paths are unaffected
//  Triggers:
//   - o_write_trigger[b] <= sw_wr[b]; o_read_trigger[b] <= sw_rd[b]
//   - exactly one-cycle pulses, cleared the following cycle
//  Mask = '0: the access is ignored entirely; no triggers, no side effects.
//  HW_ACCESS=0: i_hw_* are unused; next = s1.
// STRUCTURE
//  Shared package rggen_rtl_pkg:
//   - enums rggen_sw_write_action_e and rggen_sw_read_action_e
//   - WIDTH range check helper
//  Sub-module rggen_bit_field_next_value:
//   - combinational per-field next-value logic (stages s1/s2/next)
//   - top level holds the value, written and trigger flops
//  Generate-time assertion: WIDTH in 1..64.
//  Generate-time assertion: illegal combo SW_WRITE_ACTION=NONE with SW_WRITE_ONCE=1.
// TESTING
//  1. Reset with INITIAL_VALUE=32'h0000_00A5 -> o_value=32'hA5; triggers=0; read returns 32'hA5
//  2. CLEAR_1: value=32'hFF; write wdata=32'h0F, mask=32'hFF ->
//     next cycle value=32'hF0; o_write_trigger=32'hFF for exactly one cycle
//  3. Read CLEAR: value=32'h3C; read with mask=32'hFFFF_FFFF ->
//     o_sw_read_data=32'h3C that cycle; value=0 next cycle
//  4. Same cycle: W1C of bit0 plus i_hw_set[0]=1 -> bit0 stays 1
//  5. Same cycle: hw write of 32'h55 plus sw write of 32'hAA, mask=32'h0F -> value=32'h5A
//  6. SW_WRITE_ONCE=1: write 32'h12, then write 32'h34 -> value stays 32'h12;
//     no second write trigger; after reset asserted mid-sequence a write of 32'h34 is accepted

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for rggen bit-field storage: software access action encodings
// and an elaboration-time width check.
package rggen_rtl_pkg;

   typedef enum logic [3:0] {
      RGGEN_WRITE_DEFAULT,
      RGGEN_WRITE_NONE,
      RGGEN_WRITE_CLEAR_1,
      RGGEN_WRITE_SET_1,
      RGGEN_WRITE_TOGGLE_1,
      RGGEN_WRITE_CLEAR_0,
      RGGEN_WRITE_SET_0,
      RGGEN_WRITE_CLEAR_ALL,
      RGGEN_WRITE_SET_ALL
   } rggen_sw_write_action_e;

   typedef enum logic [1:0] {
      RGGEN_READ_NONE,
      RGGEN_READ_CLEAR,
      RGGEN_READ_SET
   } rggen_sw_read_action_e;

   localparam int RGGEN_MAX_FIELD_WIDTH = 64;

   function automatic bit rggen_width_ok(input int width);
      return (width >= 1) && (width <= RGGEN_MAX_FIELD_WIDTH);
   endfunction

endpackage

// File: rtl/rggen_bit_field_next_value.sv
// Combinational next-value logic for one field: software action, then
// hardware load, then hardware set/clear.
module rggen_bit_field_next_value
   import rggen_rtl_pkg::*;
#(
   parameter int                     WIDTH           = 32,
   parameter rggen_sw_write_action_e SW_WRITE_ACTION = RGGEN_WRITE_DEFAULT,
   parameter rggen_sw_read_action_e  SW_READ_ACTION  = RGGEN_READ_NONE,
   parameter bit                     HW_ACCESS       = 1'b1
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic [WIDTH-1:0] i_sw_wr,
   input  logic [WIDTH-1:0] i_sw_rd,
   input  logic [WIDTH-1:0] i_sw_write_data,
   input  logic             i_hw_write_enable,
   input  logic [WIDTH-1:0] i_hw_write_data,
   input  logic [WIDTH-1:0] i_hw_set,
   input  logic [WIDTH-1:0] i_hw_clear,
   output logic [WIDTH-1:0] o_next
);

   logic [WIDTH-1:0] wr_val;
   logic [WIDTH-1:0] rd_val;
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] hw_ld;
   logic [WIDTH-1:0] s2;

   always_comb begin
      wr_val = i_value;
      case (SW_WRITE_ACTION)
         RGGEN_WRITE_DEFAULT:   wr_val = i_sw_write_data;
         RGGEN_WRITE_NONE:      wr_val = i_value;
         RGGEN_WRITE_CLEAR_1:   wr_val = i_value & ~i_sw_write_data;
         RGGEN_WRITE_SET_1:     wr_val = i_value | i_sw_write_data;
         RGGEN_WRITE_TOGGLE_1:  wr_val = i_value ^ i_sw_write_data;
         RGGEN_WRITE_CLEAR_0:   wr_val = i_value & i_sw_write_data;
         RGGEN_WRITE_SET_0:     wr_val = i_value | ~i_sw_write_data;
         RGGEN_WRITE_CLEAR_ALL: wr_val = '0;
         RGGEN_WRITE_SET_ALL:   wr_val = '1;
         default:               wr_val = i_value;
      endcase
   end

   always_comb begin
      rd_val = i_value;
      case (SW_READ_ACTION)
         RGGEN_READ_CLEAR: rd_val = '0;
         RGGEN_READ_SET:   rd_val = '1;
         default:          rd_val = i_value;
      endcase
   end

   always_comb begin
      s1 = (i_sw_wr & wr_val)
         | (~i_sw_wr & i_sw_rd & rd_val)
         | (~i_sw_wr & ~i_sw_rd & i_value);
      // a hardware load only lands on bits software is not writing this cycle
      hw_ld  = HW_ACCESS ? ({WIDTH{i_hw_write_enable}} & ~i_sw_wr) : '0;
      s2     = (hw_ld & i_hw_write_data) | (~hw_ld & s1);
      o_next = HW_ACCESS ? ((s2 & ~i_hw_clear) | i_hw_set) : s2;
   end

endmodule

// File: rtl/rggen_bit_field_ext.sv
// Bit-field storage element: holds the value, write-once flag and the
// registered write/read trigger pulses for one register field.
module rggen_bit_field_ext
   import rggen_rtl_pkg::*;
#(
   parameter int                     WIDTH           = 32,
   parameter logic [WIDTH-1:0]       INITIAL_VALUE   = '0,
   parameter bit                     SW_READABLE     = 1'b1,
   parameter rggen_sw_write_action_e SW_WRITE_ACTION = RGGEN_WRITE_DEFAULT,
   parameter rggen_sw_read_action_e  SW_READ_ACTION  = RGGEN_READ_NONE,
   parameter bit                     SW_WRITE_ONCE   = 1'b0,
   parameter bit                     HW_ACCESS       = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_sw_write_valid,
   input  logic             i_sw_read_valid,
   input  logic [WIDTH-1:0] i_sw_mask,
   input  logic [WIDTH-1:0] i_sw_write_data,
   output logic [WIDTH-1:0] o_sw_read_data,
   output logic [WIDTH-1:0] o_sw_value,
   input  logic             i_hw_write_enable,
   input  logic [WIDTH-1:0] i_hw_write_data,
   input  logic [WIDTH-1:0] i_hw_set,
   input  logic [WIDTH-1:0] i_hw_clear,
   output logic [WIDTH-1:0] o_value,
   output logic [WIDTH-1:0] o_write_trigger,
   output logic [WIDTH-1:0] o_read_trigger
);

   if (!rggen_width_ok(WIDTH)) begin : g_bad_width
      $fatal(1, "rggen_bit_field_ext: WIDTH must be in 1..64");
   end
   if (SW_WRITE_ACTION == RGGEN_WRITE_NONE && SW_WRITE_ONCE) begin : g_bad_combo
      $fatal(1, "rggen_bit_field_ext: write-once with write action NONE is meaningless");
   end

   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] wr_trig_q, rd_trig_q;
   logic             written_q, written_d;
   logic [WIDTH-1:0] sw_wr;
   logic [WIDTH-1:0] sw_rd;

   assign sw_wr     = {WIDTH{i_sw_write_valid & ~(SW_WRITE_ONCE & written_q)}} & i_sw_mask;
   assign sw_rd     = {WIDTH{i_sw_read_valid}} & i_sw_mask;
   assign written_d = written_q | (|sw_wr);

   rggen_bit_field_next_value #(
      .WIDTH           (WIDTH),
      .SW_WRITE_ACTION (SW_WRITE_ACTION),
      .SW_READ_ACTION  (SW_READ_ACTION),
      .HW_ACCESS       (HW_ACCESS)
   ) u_next (
      .i_value           (value_q),
      .i_sw_wr           (sw_wr),
      .i_sw_rd           (sw_rd),
      .i_sw_write_data   (i_sw_write_data),
      .i_hw_write_enable (i_hw_write_enable),
      .i_hw_write_data   (i_hw_write_data),
      .i_hw_set          (i_hw_set),
      .i_hw_clear        (i_hw_clear),
      .o_next            (value_d)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         value_q   <= INITIAL_VALUE;
         written_q <= 1'b0;
         wr_trig_q <= '0;
         rd_trig_q <= '0;
      end else begin
         value_q   <= value_d;
         written_q <= written_d;
         wr_trig_q <= sw_wr;
         rd_trig_q <= sw_rd;
      end
   end

   // read data reflects the value before any read side effect takes hold
   assign o_sw_read_data  = SW_READABLE ? value_q : '0;
   assign o_sw_value      = value_q;
   assign o_value         = value_q;
   assign o_write_trigger = wr_trig_q;
   assign o_read_trigger  = rd_trig_q;

endmodule

// File: tb/tb_rggen_bit_field_ext.sv
// Directed bench: three field configurations sharing one stimulus bus.
module tb_rggen_bit_field_ext;
   import rggen_rtl_pkg::*;

   localparam int W = 32;

   logic         clk, rst_n;
   logic         wv, rv, hw_we;
   logic [W-1:0] mask, wdata, hw_wdata, hw_set, hw_clr;

   logic [W-1:0] a_rd, a_sv, a_val, a_wt, a_rt;
   logic [W-1:0] b_rd, b_sv, b_val, b_wt, b_rt;
   logic [W-1:0] c_rd, c_sv, c_val, c_wt, c_rt;

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A: read-clear, default write, non-zero reset value
   rggen_bit_field_ext #(
      .WIDTH(W), .INITIAL_VALUE(32'h0000_00A5),
      .SW_WRITE_ACTION(RGGEN_WRITE_DEFAULT), .SW_READ_ACTION(RGGEN_READ_CLEAR)
   ) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_sw_write_valid(wv), .i_sw_read_valid(rv),
      .i_sw_mask(mask), .i_sw_write_data(wdata), .o_sw_read_data(a_rd), .o_sw_value(a_sv),
      .i_hw_write_enable(hw_we), .i_hw_write_data(hw_wdata), .i_hw_set(hw_set),
      .i_hw_clear(hw_clr), .o_value(a_val), .o_write_trigger(a_wt), .o_read_trigger(a_rt)
   );

   // B: write-1-to-clear
   rggen_bit_field_ext #(
      .WIDTH(W), .SW_WRITE_ACTION(RGGEN_WRITE_CLEAR_1)
   ) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_sw_write_valid(wv), .i_sw_read_valid(rv),
      .i_sw_mask(mask), .i_sw_write_data(wdata), .o_sw_read_data(b_rd), .o_sw_value(b_sv),
      .i_hw_write_enable(hw_we), .i_hw_write_data(hw_wdata), .i_hw_set(hw_set),
      .i_hw_clear(hw_clr), .o_value(b_val), .o_write_trigger(b_wt), .o_read_trigger(b_rt)
   );

   // C: write-once
   rggen_bit_field_ext #(
      .WIDTH(W), .SW_WRITE_ONCE(1'b1)
   ) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_sw_write_valid(wv), .i_sw_read_valid(rv),
      .i_sw_mask(mask), .i_sw_write_data(wdata), .o_sw_read_data(c_rd), .o_sw_value(c_sv),
      .i_hw_write_enable(hw_we), .i_hw_write_data(hw_wdata), .i_hw_set(hw_set),
      .i_hw_clear(hw_clr), .o_value(c_val), .o_write_trigger(c_wt), .o_read_trigger(c_rt)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wv = 0; rv = 0; hw_we = 0;
      mask = '0; wdata = '0; hw_wdata = '0; hw_set = '0; hw_clr = '0;
   endtask

   task automatic hw_load(input logic [W-1:0] d);
      idle();
      hw_we = 1; hw_wdata = d;
      cyc();
      idle();
   endtask

   initial begin
      rst_n = 0;
      idle();
      #12;
      // reset state
      chk("rst_a_value", a_val, 32'h0000_00A5);
      chk("rst_a_rdata", a_rd, 32'h0000_00A5);
      chk("rst_a_svalue", a_sv, 32'h0000_00A5);
      chk("rst_a_wtrig", a_wt, '0);
      chk("rst_a_rtrig", a_rt, '0);
      chk("rst_b_value", b_val, '0);
      cyc();
      rst_n = 1;
      cyc();

      // read-clear: pre-effect data on the read cycle, cleared afterwards
      hw_load(32'h3C);
      chk("rc_load", a_val, 32'h3C);
      rv = 1; mask = '1;
      #1;
      chk("rc_rdata", a_rd, 32'h3C);
      cyc();
      idle();
      chk("rc_value", a_val, '0);
      chk("rc_rtrig", a_rt, 32'hFFFF_FFFF);
      chk("rc_wtrig", a_wt, '0);
      cyc();
      chk("rc_rtrig_off", a_rt, '0);

      // masked-off access does nothing
      hw_load(32'h77);
      rv = 1; wv = 1; wdata = 32'h1; mask = '0;
      cyc();
      idle();
      chk("nomask_value", a_val, 32'h77);
      chk("nomask_rtrig", a_rt, '0);
      chk("nomask_wtrig", a_wt, '0);

      // hw load 55 vs sw write AA on low nibble -> 5A
      hw_we = 1; hw_wdata = 32'h55; wv = 1; wdata = 32'hAA; mask = 32'h0F;
      cyc();
      idle();
      chk("hw_sw_merge", a_val, 32'h5A);
      chk("hw_sw_wtrig", a_wt, 32'h0F);

      // write + read same cycle: write wins, both triggers
      wv = 1; rv = 1; wdata = 32'h0123_4567; mask = '1;
      cyc();
      idle();
      chk("wr_rd_value", a_val, 32'h0123_4567);
      chk("wr_rd_wtrig", a_wt, 32'hFFFF_FFFF);
      chk("wr_rd_rtrig", a_rt, 32'hFFFF_FFFF);

      // W1C
      hw_load(32'hFF);
      chk("w1c_load", b_val, 32'hFF);
      wv = 1; wdata = 32'h0F; mask = 32'hFF;
      cyc();
      idle();
      chk("w1c_value", b_val, 32'hF0);
      chk("w1c_wtrig", b_wt, 32'hFF);
      cyc();
      chk("w1c_wtrig_off", b_wt, '0);

      // W1C vs hw_set on bit0: set wins
      hw_load(32'h01);
      wv = 1; wdata = 32'h1; mask = 32'h1; hw_set = 32'h1;
      cyc();
      idle();
      chk("w1c_vs_set", b_val, 32'h01);
      wv = 1; wdata = 32'h1; mask = 32'h1;
      cyc();
      idle();
      chk("w1c_alone", b_val, '0);

      // hw set beats hw clear
      hw_set = 32'h3; hw_clr = 32'h6;
      cyc();
      idle();
      chk("set_over_clr", b_val, 32'h3);
      hw_clr = 32'h1;
      cyc();
      idle();
      chk("hw_clr", b_val, 32'h2);

      // write-once
      rst_n = 0;
      #1;
      chk("wo_rst", c_val, '0);
      cyc();
      rst_n = 1;
      wv = 1; wdata = 32'h12; mask = '1;
      cyc();
      idle();
      chk("wo_first", c_val, 32'h12);
      chk("wo_first_trig", c_wt, 32'hFFFF_FFFF);
      wv = 1; wdata = 32'h34; mask = '1;
      cyc();
      idle();
      chk("wo_second", c_val, 32'h12);
      chk("wo_second_trig", c_wt, '0);
      hw_load(32'h99);
      chk("wo_hw_load", c_val, 32'h99);
      // reset during an access discards it and re-arms the write
      wv = 1; wdata = 32'h34; mask = '1;
      rst_n = 0;
      cyc();
      chk("wo_mid_rst", c_val, '0);
      chk("wo_mid_rst_trig", c_wt, '0);
      rst_n = 1;
      cyc();
      idle();
      chk("wo_rearmed", c_val, 32'h34);
      chk("wo_rearmed_trig", c_wt, 32'hFFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
